// File: rtl/spu_issue_scoreboard.sv
// Dual-issue hazard scoreboard in front of the REG->EX register.
// Tracks per-register result countdowns and splits dependent pairs.
module spu_issue_scoreboard #(
  parameter int NUM_REGS = 128,
  parameter int LAT_W    = 3,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_1,
  input  logic             valid_2,
  input  logic             we_1,
  input  logic             we_2,
  input  logic [RW-1:0]    rt_1,
  input  logic [RW-1:0]    rt_2,
  input  logic [LAT_W-1:0] lat_1,
  input  logic [LAT_W-1:0] lat_2,
  input  logic [RW-1:0]    ra_1,
  input  logic [RW-1:0]    rb_1,
  input  logic [RW-1:0]    rc_1,
  input  logic [RW-1:0]    ra_2,
  input  logic [RW-1:0]    rb_2,
  input  logic [RW-1:0]    rc_2,
  input  logic             use_ra_1,
  input  logic             use_rb_1,
  input  logic             use_rc_1,
  input  logic             use_ra_2,
  input  logic             use_rb_2,
  input  logic             use_rc_2,
  output logic             go_1,
  output logic             go_2,
  output logic             stall_reg,
  output logic             pending_any
);

  logic [LAT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_W-1:0] cnt_d [NUM_REGS];
  logic             done1_q;
  logic             done1_d;

  logic v1, v2;
  logic rdy1, rdy2;
  logic raw, waw, hz2;

  // Issue decision: source readiness, intra-pair hazards, in-order rule
  always_comb begin
    v1   = valid_1 & ~done1_q & ~flush;
    v2   = valid_2 & ~flush;
    rdy1 = (~use_ra_1 | (cnt_q[ra_1] == '0))
         & (~use_rb_1 | (cnt_q[rb_1] == '0))
         & (~use_rc_1 | (cnt_q[rc_1] == '0));
    rdy2 = (~use_ra_2 | (cnt_q[ra_2] == '0))
         & (~use_rb_2 | (cnt_q[rb_2] == '0))
         & (~use_rc_2 | (cnt_q[rc_2] == '0));
    raw  = v1 & we_1
         & ((use_ra_2 & (ra_2 == rt_1))
          | (use_rb_2 & (rb_2 == rt_1))
          | (use_rc_2 & (rc_2 == rt_1)));
    waw  = v1 & we_1 & we_2 & (rt_2 == rt_1);
    go_1 = v1 & rdy1;
    hz2  = ~rdy2 | raw | waw | (v1 & ~go_1);
    go_2 = v2 & ~hz2;
    stall_reg = (v1 & ~go_1) | (v2 & ~go_2);
  end

  // Pipe 1 already-issued flag for a held (split) pair
  always_comb begin
    done1_d = done1_q;
    if (flush)
      done1_d = 1'b0;
    else if (go_1 & stall_reg)
      done1_d = 1'b1;
    else if (~stall_reg)
      done1_d = 1'b0;
  end

  // Countdown next state; max keeps WAW write-back visible in order
  always_comb begin
    logic [LAT_W-1:0] base;
    pending_any = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      base = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
      cnt_d[r] = base;
      if (go_1 & we_1 & (rt_1 == RW'(r)))
        cnt_d[r] = (lat_1 > base) ? lat_1 : base;
      else if (go_2 & we_2 & (rt_2 == RW'(r)))
        cnt_d[r] = (lat_2 > base) ? lat_2 : base;
      pending_any = pending_any | (cnt_q[r] != '0);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      done1_q <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= '0;
    end else begin
      done1_q <= done1_d;
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= cnt_d[r];
    end
  end

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// Directed testbench for spu_issue_scoreboard.
// Each task drives one scenario and checks outputs inline.
module tb_spu_issue_scoreboard;

  logic       clk = 1'b0;
  logic       reset, flush;
  logic       valid_1, valid_2, we_1, we_2;
  logic [6:0] rt_1, rt_2;
  logic [2:0] lat_1, lat_2;
  logic [6:0] ra_1, rb_1, rc_1, ra_2, rb_2, rc_2;
  logic       use_ra_1, use_rb_1, use_rc_1;
  logic       use_ra_2, use_rb_2, use_rc_2;
  logic       go_1, go_2, stall_reg, pending_any;

  int n_vec = 0;
  int n_err = 0;

  spu_issue_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_1(valid_1), .valid_2(valid_2),
    .we_1(we_1), .we_2(we_2),
    .rt_1(rt_1), .rt_2(rt_2),
    .lat_1(lat_1), .lat_2(lat_2),
    .ra_1(ra_1), .rb_1(rb_1), .rc_1(rc_1),
    .ra_2(ra_2), .rb_2(rb_2), .rc_2(rc_2),
    .use_ra_1(use_ra_1), .use_rb_1(use_rb_1),
    .use_rc_1(use_rc_1),
    .use_ra_2(use_ra_2), .use_rb_2(use_rb_2),
    .use_rc_2(use_rc_2),
    .go_1(go_1), .go_2(go_2),
    .stall_reg(stall_reg), .pending_any(pending_any)
  );

  always #5 clk = ~clk;

  // Advance one clock edge; inputs change and outputs settle #1 later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; valid_1 = 0; valid_2 = 0; we_1 = 0; we_2 = 0;
    rt_1 = 0; rt_2 = 0; lat_1 = 0; lat_2 = 0;
    ra_1 = 0; rb_1 = 0; rc_1 = 0; ra_2 = 0; rb_2 = 0; rc_2 = 0;
    use_ra_1 = 0; use_rb_1 = 0; use_rc_1 = 0;
    use_ra_2 = 0; use_rb_2 = 0; use_rc_2 = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    step();
    step();
    reset = 0;
    #1;
    n_vec++; if (pending_any !== 1'b0) begin n_err++; $display("FAIL reset_pending got %b want 0", pending_any); end
    n_vec++; if (dut.done1_q !== 1'b0) begin n_err++; $display("FAIL reset_done1 got %b want 0", dut.done1_q); end
    valid_1 = 1; valid_2 = 1; ra_2 = 3; use_ra_2 = 1;
    #1;
    n_vec++; if ({go_1, go_2, stall_reg} !== 3'b110) begin n_err++; $display("FAIL reset_go got %b want 110", {go_1, go_2, stall_reg}); end
    idle();
    step();
  endtask

  task automatic test_independent();
    valid_1 = 1; valid_2 = 1; we_1 = 1; we_2 = 1;
    rt_1 = 5; lat_1 = 3; rt_2 = 6; lat_2 = 2;
    ra_1 = 1; rb_1 = 2; use_ra_1 = 1; use_rb_1 = 1;
    ra_2 = 3; rc_2 = 4; use_ra_2 = 1; use_rc_2 = 1;
    #1;
    n_vec++; if ({go_1, go_2, stall_reg} !== 3'b110) begin n_err++; $display("FAIL indep_go got %b want 110", {go_1, go_2, stall_reg}); end
    step();
    idle();
    #1;
    n_vec++; if (dut.cnt_q[5] !== 3'd3) begin n_err++; $display("FAIL indep_cnt5 got %0d want 3", dut.cnt_q[5]); end
    n_vec++; if (dut.cnt_q[6] !== 3'd2) begin n_err++; $display("FAIL indep_cnt6 got %0d want 2", dut.cnt_q[6]); end
    n_vec++; if (pending_any !== 1'b1) begin n_err++; $display("FAIL indep_pending got %b want 1", pending_any); end
    repeat (3) step();
    n_vec++; if (pending_any !== 1'b0) begin n_err++; $display("FAIL indep_drain got %b want 0", pending_any); end
  endtask

  task automatic test_raw_cross();
    valid_1 = 1; we_1 = 1; rt_1 = 5; lat_1 = 3;
    #1;
    n_vec++; if (go_1 !== 1'b1) begin n_err++; $display("FAIL rawx_prod got %b want 1", go_1); end
    step();
    idle();
    valid_1 = 1; ra_1 = 5; use_ra_1 = 1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_vec++; if ({go_1, stall_reg, pending_any} !== 3'b011) begin n_err++; $display("FAIL rawx_stall c%0d got %b want 011", c, {go_1, stall_reg, pending_any}); end
      step();
    end
    #1;
    n_vec++; if ({go_1, stall_reg, pending_any} !== 3'b100) begin n_err++; $display("FAIL rawx_go got %b want 100", {go_1, stall_reg, pending_any}); end
    step();
    idle();
  endtask

  task automatic test_split();
    valid_1 = 1; valid_2 = 1; we_1 = 1; rt_1 = 9; lat_1 = 2;
    ra_2 = 9; use_ra_2 = 1;
    #1;
    n_vec++; if ({go_1, go_2, stall_reg} !== 3'b101) begin n_err++; $display("FAIL split_c0 got %b want 101", {go_1, go_2, stall_reg}); end
    step();
    n_vec++; if (dut.done1_q !== 1'b1) begin n_err++; $display("FAIL split_done1 got %b want 1", dut.done1_q); end
    n_vec++; if ({go_1, go_2, stall_reg} !== 3'b001) begin n_err++; $display("FAIL split_c1 got %b want 001", {go_1, go_2, stall_reg}); end
    step();
    n_vec++; if ({go_1, go_2, stall_reg} !== 3'b001) begin n_err++; $display("FAIL split_c2 got %b want 001", {go_1, go_2, stall_reg}); end
    step();
    n_vec++; if ({go_1, go_2, stall_reg} !== 3'b010) begin n_err++; $display("FAIL split_c3 got %b want 010", {go_1, go_2, stall_reg}); end
    step();
    n_vec++; if (dut.done1_q !== 1'b0) begin n_err++; $display("FAIL split_clear got %b want 0", dut.done1_q); end
    idle();
  endtask

  task automatic test_waw();
    valid_1 = 1; we_1 = 1; rt_1 = 7; lat_1 = 5;
    step();
    n_vec++; if (dut.cnt_q[7] !== 3'd5) begin n_err++; $display("FAIL waw_seed got %0d want 5", dut.cnt_q[7]); end
    lat_1 = 2;
    #1;
    n_vec++; if (go_1 !== 1'b1) begin n_err++; $display("FAIL waw_go got %b want 1", go_1); end
    step();
    idle();
    #1;
    n_vec++; if (dut.cnt_q[7] !== 3'd4) begin n_err++; $display("FAIL waw_max got %0d want 4", dut.cnt_q[7]); end
    repeat (4) step();
    valid_1 = 1; valid_2 = 1; we_1 = 1; we_2 = 1;
    rt_1 = 7; rt_2 = 7; lat_1 = 1; lat_2 = 1;
    #1;
    n_vec++; if ({go_1, go_2, stall_reg} !== 3'b101) begin n_err++; $display("FAIL waw_pair got %b want 101", {go_1, go_2, stall_reg}); end
    step();
    n_vec++; if ({go_1, go_2, stall_reg} !== 3'b010) begin n_err++; $display("FAIL waw_pair2 got %b want 010", {go_1, go_2, stall_reg}); end
    step();
    idle();
    repeat (2) step();
  endtask

  task automatic test_flush();
    valid_1 = 1; valid_2 = 1; we_1 = 1; rt_1 = 9; lat_1 = 4;
    ra_2 = 9; use_ra_2 = 1;
    step();
    flush = 1;
    #1;
    n_vec++; if ({go_1, go_2, stall_reg} !== 3'b000) begin n_err++; $display("FAIL flush_out got %b want 000", {go_1, go_2, stall_reg}); end
    step();
    idle();
    n_vec++; if (dut.done1_q !== 1'b0) begin n_err++; $display("FAIL flush_done1 got %b want 0", dut.done1_q); end
    n_vec++; if (dut.cnt_q[9] !== 3'd3) begin n_err++; $display("FAIL flush_cnt got %0d want 3", dut.cnt_q[9]); end
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    valid_1 = 1; valid_2 = 1; we_1 = 1; we_2 = 1;
    rt_1 = 10; lat_1 = 7; rt_2 = 11; lat_2 = 6;
    step();
    idle();
    n_vec++; if (pending_any !== 1'b1) begin n_err++; $display("FAIL rstm_pend got %b want 1", pending_any); end
    reset = 1;
    step();
    reset = 0;
    #1;
    n_vec++; if (pending_any !== 1'b0) begin n_err++; $display("FAIL rstm_clear got %b want 0", pending_any); end
    valid_1 = 1; valid_2 = 1; we_1 = 1; rt_1 = 12;
    ra_1 = 10; use_ra_1 = 1; ra_2 = 11; use_ra_2 = 1;
    #1;
    n_vec++; if ({go_1, go_2, stall_reg} !== 3'b110) begin n_err++; $display("FAIL rstm_go got %b want 110", {go_1, go_2, stall_reg}); end
    step();
    idle();
  endtask

  task automatic test_back_to_back();
    valid_1 = 1; we_1 = 1; rt_1 = 20; lat_1 = 0;
    step();
    idle();
    valid_1 = 1; ra_1 = 20; use_ra_1 = 1;
    #1;
    n_vec++; if ({go_1, stall_reg, pending_any} !== 3'b100) begin n_err++; $display("FAIL b2b got %b want 100", {go_1, stall_reg, pending_any}); end
    step();
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_independent();
    test_raw_cross();
    test_split();
    test_waw();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
